// File: rtl/cdc_deglitch.sv
// cdc_deglitch: debounce filter for an already-synchronized level, with rise/fall pulses.
// Define CDC_DEGLITCH_EVT_CNT_EN to add a saturating accepted-transition counter.
module cdc_deglitch #(
  parameter int   CNT_WIDTH = 8,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] thr_i,
  input  logic                 dat_i,
  output logic                 dat_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 busy_o
`ifdef CDC_DEGLITCH_EVT_CNT_EN
  ,
  input  logic                 evt_clr_i,
  output logic [15:0]          evt_cnt_o
`endif
);
  typedef enum logic {STABLE, CHECK} state_t;
  state_t r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic r_dat, r_rise, r_fall;
  logic w_dat_nxt, w_rise_nxt, w_fall_nxt, w_diff, w_acc;
  // cnt < thr_i whenever it increments, so it cannot wrap
  always_comb begin
    w_diff      = en_i && (dat_i != r_dat);
    w_acc       = w_diff && (r_cnt >= thr_i);
    w_state_nxt = (w_diff && !w_acc) ? CHECK : STABLE;
    w_cnt_nxt   = (w_diff && !w_acc) ? r_cnt + 1'b1 : '0;
    w_dat_nxt   = w_acc ? dat_i : r_dat;
    w_rise_nxt  = w_acc && dat_i;
    w_fall_nxt  = w_acc && !dat_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_dat   <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dat   <= w_dat_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end
  assign dat_o  = r_dat;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign busy_o = (r_state == CHECK);
`ifdef CDC_DEGLITCH_EVT_CNT_EN
  logic [15:0] r_evt;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || evt_clr_i) r_evt <= '0;
    else if ((r_rise || r_fall) && r_evt != 16'hFFFF) r_evt <= r_evt + 16'd1;
  end
  assign evt_cnt_o = r_evt;
`endif
endmodule

// File: tb/tb_cdc_deglitch.sv
// tb_cdc_deglitch: directed checks of filtering, latency, threshold changes, reset and enable.
module tb_cdc_deglitch;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, dat = 1'b0;
  logic [7:0] thr = '0;
  logic dat_o, rise_o, fall_o, busy_o;
  int errs = 0, checks = 0;
`ifdef CDC_DEGLITCH_EVT_CNT_EN
  logic evt_clr = 1'b0;
  logic [15:0] evt_cnt;
`endif
  always #5 clk = ~clk;
  cdc_deglitch #(.CNT_WIDTH(8), .RST_VAL(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .thr_i(thr), .dat_i(dat),
    .dat_o(dat_o), .rise_o(rise_o), .fall_o(fall_o), .busy_o(busy_o)
`ifdef CDC_DEGLITCH_EVT_CNT_EN
    , .evt_clr_i(evt_clr), .evt_cnt_o(evt_cnt)
`endif
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // exp = {dat_o, rise_o, fall_o, busy_o}
  task automatic chk(input string name, input logic [3:0] exp);
    step();
    checks++;
    if ({dat_o, rise_o, fall_o, busy_o} !== exp) begin
      errs++;
      $display("FAIL %s: got {dat,rise,fall,busy}=%b expected %b", name, {dat_o, rise_o, fall_o, busy_o}, exp);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; thr = 8'd0; dat = 1'b1;
    chk("reset_priority", 4'b0000);
    chk("reset_hold", 4'b0000);
    rst_n = 1'b1; dat = 1'b0;
    chk("reset_release", 4'b0000);
  endtask
  task automatic test_latency;
    thr = 8'd3; dat = 1'b1;
    for (int e = 0; e < 5; e++) chk($sformatf("rise_edge%0d", e), {e >= 3, e == 3, 1'b0, e < 3});
    dat = 1'b0;
    for (int e = 0; e < 5; e++) chk($sformatf("fall_edge%0d", e), {e < 3, 1'b0, e == 3, e < 3});
  endtask
  task automatic test_glitch;
    thr = 8'd3; dat = 1'b1;
    for (int e = 0; e < 3; e++) chk($sformatf("glitch_busy%0d", e), 4'b0001);
    dat = 1'b0;
    chk("glitch_reject", 4'b0000);
    dat = 1'b1;
    for (int e = 0; e < 4; e++) chk($sformatf("glitch_requal%0d", e), {e == 3, e == 3, 1'b0, e < 3});
    thr = 8'd0; dat = 1'b0;
    chk("glitch_restore", 4'b0010);
  endtask
  task automatic test_back_to_back;
    thr = 8'd0;
    for (int i = 0; i < 8; i++) begin
      dat = (i % 2 == 0);
      chk($sformatf("toggle%0d", i), {dat, dat, !dat, 1'b0});
    end
  endtask
  task automatic test_thr_change;
    thr = 8'd10; dat = 1'b1;
    for (int e = 0; e < 5; e++) chk($sformatf("thr10_busy%0d", e), 4'b0001);
    thr = 8'd2;
    chk("thr_lowered_flip", 4'b1100);
    thr = 8'd0; dat = 1'b0;
    chk("thr_restore", 4'b0010);
  endtask
  task automatic test_enable_drop;
    thr = 8'd0; dat = 1'b1;
    chk("en_setup", 4'b1100);
    thr = 8'd10; dat = 1'b0;
    for (int e = 0; e < 4; e++) chk($sformatf("en_busy%0d", e), 4'b1001);
    en = 1'b0;
    chk("en_drop", 4'b1000);
    thr = 8'd0;
    chk("en_off_hold", 4'b1000);
    en = 1'b1; thr = 8'd1;
    chk("en_requal0", 4'b1001);
    chk("en_requal1", 4'b0010);
  endtask
  task automatic test_reset_mid;
    thr = 8'd0; dat = 1'b1;
    chk("rst_setup", 4'b1100);
    thr = 8'd10; dat = 1'b0;
    for (int e = 0; e < 4; e++) chk($sformatf("rst_busy%0d", e), 4'b1001);
    rst_n = 1'b0;
    chk("rst_mid_check", 4'b0000);
    rst_n = 1'b1;
    chk("rst_after", 4'b0000);
  endtask
`ifdef CDC_DEGLITCH_EVT_CNT_EN
  task automatic test_evt;
    evt_clr = 1'b1; step(); evt_clr = 1'b0; thr = 8'd0;
    for (int i = 0; i < 65537; i++) begin dat = ~dat_o; step(); end
    step();
    checks++;
    if (evt_cnt !== 16'hFFFF) begin errs++; $display("FAIL evt_saturate: got %h expected ffff", evt_cnt); end
    dat = ~dat_o; step();
    evt_clr = 1'b1; step(); evt_clr = 1'b0;
    checks++;
    if (evt_cnt !== 16'h0000) begin errs++; $display("FAIL evt_clear_wins: got %h expected 0000", evt_cnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_back_to_back();
    test_thr_change();
    test_enable_drop();
    test_reset_mid();
`ifdef CDC_DEGLITCH_EVT_CNT_EN
    test_evt();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
